// File: rtl/sr_trace_fifo.sv
// Instruction trace FIFO (first-word-fall-through) with sticky overflow and saturating drop counter.
// Optional per-entry cycle timestamp enabled by defining SR_TRACE_TIMESTAMP_EN.
module sr_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cap_en,
    input  logic                     cap_valid_i,
    input  logic [31:0]              pc_i,
    input  logic [31:0]              instr_i,
    input  logic                     flush_i,
    output logic                     tr_valid_o,
    input  logic                     tr_ready_i,
    output logic [31:0]              tr_pc_o,
    output logic [31:0]              tr_instr_o,
`ifdef SR_TRACE_TIMESTAMP_EN
    output logic [31:0]              tr_cycle_o,
`endif
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic [CNT_W-1:0]         drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
`ifdef SR_TRACE_TIMESTAMP_EN
    localparam int EW = 96;
`else
    localparam int EW = 64;
`endif
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [EW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic [CNT_W-1:0] r_drop_cnt;

    logic             w_full;
    logic             w_cap;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_clear;
    logic [EW-1:0]    w_entry;
    logic [EW-1:0]    w_head;

`ifdef SR_TRACE_TIMESTAMP_EN
    logic [31:0]      r_cycle;

    // Free-running; deliberately unaffected by flush and cap_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    assign w_entry    = {pc_i, instr_i, r_cycle};
    assign tr_cycle_o = w_head[31:0];
`else
    assign w_entry    = {pc_i, instr_i};
`endif

    assign w_full     = (r_count == FULL_CNT);
    assign w_cap      = cap_en & cap_valid_i;
    assign w_pop      = tr_valid_o & tr_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push     = w_cap & (~w_full | w_pop);
    assign w_drop     = w_cap & w_full & ~w_pop;
    assign w_clear    = rst | flush_i;

    assign w_head     = r_mem[r_rd_ptr];
    assign tr_valid_o = (r_count != '0);
    assign tr_pc_o    = w_head[EW-1 -: 32];
    assign tr_instr_o = w_head[EW-33 -: 32];
    assign count_o    = r_count;
    assign overflow_o = r_overflow;
    assign drop_cnt_o = r_drop_cnt;

    always_ff @(posedge clk) begin
        if (w_push && !w_clear) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sr_trace_fifo.sv
// Scoreboard bench for sr_trace_fifo: directed stimulus pushes expected entries, a monitor checks handshakes.
module tb_sr_trace_fifo;

    logic        clk = 1'b0;
    logic        rst, cap_en, cap_valid_i, flush_i, tr_ready_i;
    logic [31:0] pc_i, instr_i;
    logic        tr_valid_o, overflow_o;
    logic [31:0] tr_pc_o, tr_instr_o;
    logic [4:0]  count_o;
    logic [15:0] drop_cnt_o;
`ifdef SR_TRACE_TIMESTAMP_EN
    logic [31:0] tr_cycle_o;
    logic [31:0] s_cycle;
`endif

    logic        s_rst, s_cap_en, s_cap_valid, s_flush, s_ready;
    logic [31:0] s_pc, s_instr;
    logic        s_valid, s_overflow;
    logic [31:0] s_pc_o, s_instr_o;
    logic [1:0]  s_count;
    logic [1:0]  s_drop;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    sr_trace_fifo #(.DEPTH(16), .CNT_W(16)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .cap_en     (cap_en),
        .cap_valid_i(cap_valid_i),
        .pc_i       (pc_i),
        .instr_i    (instr_i),
        .flush_i    (flush_i),
        .tr_valid_o (tr_valid_o),
        .tr_ready_i (tr_ready_i),
        .tr_pc_o    (tr_pc_o),
        .tr_instr_o (tr_instr_o),
`ifdef SR_TRACE_TIMESTAMP_EN
        .tr_cycle_o (tr_cycle_o),
`endif
        .count_o    (count_o),
        .overflow_o (overflow_o),
        .drop_cnt_o (drop_cnt_o)
    );

    sr_trace_fifo #(.DEPTH(2), .CNT_W(2)) u_small (
        .clk        (clk),
        .rst        (s_rst),
        .cap_en     (s_cap_en),
        .cap_valid_i(s_cap_valid),
        .pc_i       (s_pc),
        .instr_i    (s_instr),
        .flush_i    (s_flush),
        .tr_valid_o (s_valid),
        .tr_ready_i (s_ready),
        .tr_pc_o    (s_pc_o),
        .tr_instr_o (s_instr_o),
`ifdef SR_TRACE_TIMESTAMP_EN
        .tr_cycle_o (s_cycle),
`endif
        .count_o    (s_count),
        .overflow_o (s_overflow),
        .drop_cnt_o (s_drop)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cap(input logic [31:0] pc, input logic [31:0] ins, input bit expect_accept);
        cap_en      = 1'b1;
        cap_valid_i = 1'b1;
        pc_i        = pc;
        instr_i     = ins;
        if (expect_accept) exp_q.push_back('{pc: pc, instr: ins});
    endtask

    // Monitor: every accepted handshake must match the next scoreboard entry.
    always @(negedge clk) begin
        ent_t e;
        if (!rst && !flush_i && tr_valid_o && tr_ready_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL out_unexpected: got pc 0x%08h expected no output", tr_pc_o);
            end else begin
                e = exp_q.pop_front();
                check("out_pc", tr_pc_o, e.pc);
                check("out_instr", tr_instr_o, e.instr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pcs [3];
        logic [31:0] ins [3];
        pcs = '{32'h0, 32'h4, 32'h8};
        ins = '{32'h00500513, 32'h00150513, 32'hFE000EE3};

        rst = 1'b1; cap_en = 1'b0; cap_valid_i = 1'b0; flush_i = 1'b0; tr_ready_i = 1'b0;
        pc_i = '0; instr_i = '0;
        s_rst = 1'b1; s_cap_en = 1'b0; s_cap_valid = 1'b0; s_flush = 1'b0; s_ready = 1'b0;
        s_pc = '0; s_instr = '0;
        tick();
        tick();
        rst = 1'b0;
        s_rst = 1'b0;
        // cycle 0 after reset release
        check("rst_count", count_o, 0);
        check("rst_valid", tr_valid_o, 0);
        check("rst_overflow", overflow_o, 0);
        check("rst_drop", drop_cnt_o, 0);

`ifdef SR_TRACE_TIMESTAMP_EN
        tick(); tick(); tick();
        set_cap(32'h10, 32'h13, 1'b1);
        tick();
        cap_valid_i = 1'b0;
        tick(); tick(); tick();
        set_cap(32'h14, 32'h13, 1'b1);
        tick();
        cap_valid_i = 1'b0;
        check("ts_first", tr_cycle_o, 3);
        tr_ready_i = 1'b1;
        tick();
        check("ts_second", tr_cycle_o, 7);
        tick();
        tr_ready_i = 1'b0;
`endif

        // Streaming with consumer always ready
        tr_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_cap(pcs[i], ins[i], 1'b1);
            if (i == 0) check("no_bypass", tr_valid_o, 0);
            tick();
            check("stream_count", count_o, 1);
        end
        cap_valid_i = 1'b0;
        tick();
        check("stream_drain", count_o, 0);

        // Overfill with consumer stalled
        tr_ready_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            set_cap(32'h1000 + 32'(i) * 4, 32'hA5000000 | 32'(i), i < 16);
            if (i == 16) begin
                check("full_count", count_o, 16);
                check("full_no_ovf", overflow_o, 0);
            end
            tick();
        end
        cap_valid_i = 1'b0;
        check("ovf_count", count_o, 16);
        check("ovf_flag", overflow_o, 1);
        check("ovf_drop", drop_cnt_o, 4);
        check("ovf_head_pc", tr_pc_o, 32'h1000);

        cap_en = 1'b0; cap_valid_i = 1'b1;
        tick();
        cap_valid_i = 1'b0;
        check("capen_off_drop", drop_cnt_o, 4);

        // Full with simultaneous push and pop
        tr_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_cap(32'h2000 + 32'(i) * 4, 32'h5A000000 | 32'(i), 1'b1);
            tick();
            check("pp_count", count_o, 16);
        end
        cap_valid_i = 1'b0;
        check("pp_drop", drop_cnt_o, 4);
        for (int i = 0; i < 16; i++) tick();
        check("wrap_drain_count", count_o, 0);
        check("wrap_drain_sb", exp_q.size(), 0);

        // Flush overrides push and pop
        tr_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_cap(32'h3000 + 32'(i) * 4, 32'h33000000 | 32'(i), 1'b1);
            tick();
        end
        cap_valid_i = 1'b0;
        check("pre_flush_count", count_o, 8);
        flush_i = 1'b1; tr_ready_i = 1'b1;
        set_cap(32'h3F00, 32'h3F3F3F3F, 1'b0);
        exp_q.delete();
        tick();
        flush_i = 1'b0; cap_valid_i = 1'b0; tr_ready_i = 1'b0;
        check("flush_count", count_o, 0);
        check("flush_valid", tr_valid_o, 0);
        check("flush_overflow", overflow_o, 0);
        check("flush_drop", drop_cnt_o, 0);
        tr_ready_i = 1'b1;
        set_cap(32'h4000, 32'h44444444, 1'b1);
        tick();
        cap_valid_i = 1'b0;
        tick();
        check("post_flush_count", count_o, 0);

        // Reset mid-operation with a capture pending
        tr_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_cap(32'h5000 + 32'(i) * 4, 32'h55000000 | 32'(i), 1'b1);
            tick();
        end
        check("pre_rst_count", count_o, 5);
        rst = 1'b1;
        set_cap(32'h5F00, 32'h5F5F5F5F, 1'b0);
        exp_q.delete();
        tick();
        rst = 1'b0; cap_valid_i = 1'b0;
        check("midrst_count", count_o, 0);
        check("midrst_valid", tr_valid_o, 0);
        tick();
        check("midrst_lost", count_o, 0);

        // Drop counter saturation on a 2-deep, 2-bit-counter instance
        s_cap_en = 1'b1; s_cap_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_pc = 32'h6000 + 32'(i) * 4;
            tick();
        end
        check("sat_drop3", s_drop, 3);
        tick();
        tick();
        s_cap_valid = 1'b0;
        check("sat_hold", s_drop, 3);
        check("sat_count", s_count, 2);
        check("sat_ovf", s_overflow, 1);
        check("sat_head", s_pc_o, 32'h6000);

        tick();
        check("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
